// File: rtl/dma_cfg_slave_pkg.sv
// dma_pkg: shared definitions for the DMA configuration slave.
//   - register word offsets (address bits [5:2])
//   - AXI response and burst encodings
//   - write/read channel state enums
//   - small helpers for address stepping, decode and byte-lane merging
package dma_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_SRC    = 4'd1;
  localparam logic [3:0] OFF_DST    = 4'd2;
  localparam logic [3:0] OFF_LEN    = 4'd3;
  localparam logic [3:0] OFF_STATUS = 4'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // Anything above STATUS in the word-offset space has no register behind it.
  function automatic logic is_unmapped(input logic [3:0] off);
    return (off > OFF_STATUS);
  endfunction

  // FIXED bursts stay on one word; every other burst type steps one word.
  function automatic logic [3:0] next_off(input logic [3:0] off, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? off : (off + 4'd1);
  endfunction

  // Replace only the byte lanes selected by the write strobe.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_cfg_slave_regs.sv
// dma_cfg_regs: DMA configuration register file.
//   we_i/waddr_i/wdata_i/wstrb_i : byte-strobed write port (word offset)
//   raddr_i -> rdata_o/rerr_o    : combinational read decode, rerr_o on unmapped
//   done_i                       : engine completion pulse, sets sticky STATUS[0]
//   dmaen_o/src_o/dst_o/len_o    : register contents to the engine
//   done_o                       : STATUS[0]
module dma_cfg_regs
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic [3:0]  raddr_i,
  input  logic        done_i,
  output logic [31:0] rdata_o,
  output logic        rerr_o,
  output logic        dmaen_o,
  output logic [31:0] src_o,
  output logic [31:0] dst_o,
  output logic [31:0] len_o,
  output logic        done_o
);

  logic        ctrl_q, ctrl_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic        status_q, status_d;
  logic        clr_s;

  // Register next-state: strobed writes, and done-set taking priority over W1C clear.
  always_comb begin
    ctrl_d = ctrl_q;
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    clr_s  = 1'b0;
    if (we_i) begin
      case (waddr_i)
        OFF_CTRL:   ctrl_d = wstrb_i[0] ? wdata_i[0] : ctrl_q;
        OFF_SRC:    src_d  = strb_merge(src_q, wdata_i, wstrb_i);
        OFF_DST:    dst_d  = strb_merge(dst_q, wdata_i, wstrb_i);
        OFF_LEN:    len_d  = strb_merge(len_q, wdata_i, wstrb_i);
        OFF_STATUS: clr_s  = wstrb_i[0] & wdata_i[0];
        default:    clr_s  = 1'b0;
      endcase
    end else begin
      clr_s = 1'b0;
    end
    if (done_i) begin
      status_d = 1'b1;
    end else if (clr_s) begin
      status_d = 1'b0;
    end else begin
      status_d = status_q;
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= 1'b0;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      len_q    <= 32'd0;
      status_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      status_q <= status_d;
    end
  end

  // Read decode; single-bit registers read back zero-extended.
  always_comb begin
    rdata_o = 32'd0;
    rerr_o  = 1'b0;
    case (raddr_i)
      OFF_CTRL:   rdata_o = {31'd0, ctrl_q};
      OFF_SRC:    rdata_o = src_q;
      OFF_DST:    rdata_o = dst_q;
      OFF_LEN:    rdata_o = len_q;
      OFF_STATUS: rdata_o = {31'd0, status_q};
      default:    rerr_o  = 1'b1;
    endcase
  end

  assign dmaen_o = ctrl_q;
  assign src_o   = src_q;
  assign dst_o   = dst_q;
  assign len_o   = len_q;
  assign done_o  = status_q;

endmodule

// File: rtl/dma_cfg_slave.sv
// dma_cfg_slave: AXI4 slave holding the DMA configuration registers.
//   S_AW*/S_W*/S_B* : write channels (single, INCR and FIXED bursts)
//   S_AR*/S_R*      : read channels (single, INCR and FIXED bursts)
//   dma_done        : engine completion pulse -> sticky DMA_interrupt (W1C)
//   DMAEN/DMASRC/DMADST/DMALEN : register contents to the engine
// Write and read channels are independent FSMs sharing one register file.
module dma_cfg_slave
  import dma_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   S_AWID,
  input  logic [ADDR_W-1:0] S_AWAddr,
  input  logic [LEN_W-1:0]  S_AWLen,
  input  logic [2:0]        S_AWSize,
  input  logic [1:0]        S_AWBurst,
  input  logic              S_AWValid,
  output logic              S_AWReady,
  input  logic [DATA_W-1:0] S_WData,
  input  logic [3:0]        S_WStrb,
  input  logic              S_WLast,
  input  logic              S_WValid,
  output logic              S_WReady,
  output logic [ID_W-1:0]   S_BID,
  output logic [1:0]        S_BResp,
  output logic              S_BValid,
  input  logic              S_BReady,
  input  logic [ID_W-1:0]   S_ARID,
  input  logic [ADDR_W-1:0] S_ARAddr,
  input  logic [LEN_W-1:0]  S_ARLen,
  input  logic [2:0]        S_ARSize,
  input  logic [1:0]        S_ARBurst,
  input  logic              S_ARValid,
  output logic              S_ARReady,
  output logic [ID_W-1:0]   S_RID,
  output logic [DATA_W-1:0] S_RData,
  output logic [1:0]        S_RResp,
  output logic              S_RLast,
  output logic              S_RValid,
  input  logic              S_RReady,
  input  logic              dma_done,
  output logic              DMAEN,
  output logic [31:0]       DMASRC,
  output logic [31:0]       DMADST,
  output logic [31:0]       DMALEN,
  output logic              DMA_interrupt
);

  wstate_e           w_state_q, w_state_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [3:0]        waddr_q, waddr_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              werr_q, werr_d;
  logic              awready_q, wready_q, bvalid_q;
  logic              reg_we_s;

  rstate_e           r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [3:0]        raddr_q, raddr_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d;
  logic [LEN_W-1:0]  rcnt_q, rcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              arready_q, rvalid_q;

  logic [3:0]        rd_off_s;
  logic [31:0]       reg_rdata_s;
  logic              reg_rerr_s;
  logic              unused_s;

  // Address, size and AWLen bits that carry no meaning for a 32-bit word register file.
  assign unused_s = ^{S_AWAddr[ADDR_W-1:6], S_AWAddr[1:0], S_ARAddr[ADDR_W-1:6],
                      S_ARAddr[1:0], S_AWLen, S_AWSize, S_ARSize};

  // Read data is fetched one beat ahead: the AR address while idle, else the next beat's address.
  assign rd_off_s = (r_state_q == R_IDLE) ? S_ARAddr[5:2] : next_off(raddr_q, rburst_q);

  dma_cfg_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .we_i    (reg_we_s),
    .waddr_i (waddr_q),
    .wdata_i (S_WData[31:0]),
    .wstrb_i (S_WStrb),
    .raddr_i (rd_off_s),
    .done_i  (dma_done),
    .rdata_o (reg_rdata_s),
    .rerr_o  (reg_rerr_s),
    .dmaen_o (DMAEN),
    .src_o   (DMASRC),
    .dst_o   (DMADST),
    .len_o   (DMALEN),
    .done_o  (DMA_interrupt)
  );

  // Write channel next-state; WLast alone ends the burst regardless of AWLen.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    reg_we_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (S_AWValid && awready_q) begin
          w_state_d = W_DATA;
          awid_d    = S_AWID;
          waddr_d   = S_AWAddr[5:2];
          wburst_d  = S_AWBurst;
          werr_d    = 1'b0;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (S_WValid && wready_q) begin
          reg_we_s = 1'b1;
          werr_d   = werr_q | is_unmapped(waddr_q);
          waddr_d  = next_off(waddr_q, wburst_q);
          w_state_d = S_WLast ? W_RESP : W_DATA;
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (S_BReady && bvalid_q) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel state; handshake flags are registered so they stay low through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      awid_q    <= {ID_W{1'b0}};
      waddr_q   <= 4'd0;
      wburst_q  <= 2'b00;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
    end
  end

  // Read channel next-state; beat payload is captured so it holds while stalled.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rburst_d  = rburst_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_ARValid && arready_q) begin
          r_state_d = R_DATA;
          rid_d     = S_ARID;
          raddr_d   = S_ARAddr[5:2];
          rburst_d  = S_ARBurst;
          rlen_d    = S_ARLen;
          rcnt_d    = {LEN_W{1'b0}};
          rdata_d   = reg_rdata_s;
          rresp_d   = reg_rerr_s ? RESP_SLVERR : RESP_OKAY;
          rlast_d   = (S_ARLen == {LEN_W{1'b0}});
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_RReady && rvalid_q) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            raddr_d = rd_off_s;
            rcnt_d  = rcnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
            rdata_d = reg_rdata_s;
            rresp_d = reg_rerr_s ? RESP_SLVERR : RESP_OKAY;
            rlast_d = ((rcnt_q + {{(LEN_W-1){1'b0}}, 1'b1}) == rlen_q);
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel state and registered R payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= {ID_W{1'b0}};
      raddr_q   <= 4'd0;
      rburst_q  <= 2'b00;
      rlen_q    <= {LEN_W{1'b0}};
      rcnt_q    <= {LEN_W{1'b0}};
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rburst_q  <= rburst_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_DATA);
    end
  end

  assign S_AWReady = awready_q;
  assign S_WReady  = wready_q;
  assign S_BValid  = bvalid_q;
  assign S_BID     = awid_q;
  assign S_BResp   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign S_ARReady = arready_q;
  assign S_RValid  = rvalid_q;
  assign S_RID     = rid_q;
  assign S_RData   = rdata_q;
  assign S_RResp   = rresp_q;
  assign S_RLast   = rlast_q;

endmodule

// File: tb/tb_dma_cfg_slave.sv
module tb_dma_cfg_slave;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  S_AWID = 8'd0, S_ARID = 8'd0;
  logic [31:0] S_AWAddr = 32'd0, S_ARAddr = 32'd0;
  logic [3:0]  S_AWLen = 4'd0, S_ARLen = 4'd0;
  logic [2:0]  S_AWSize = 3'd0, S_ARSize = 3'd0;
  logic [1:0]  S_AWBurst = 2'd0, S_ARBurst = 2'd0;
  logic        S_AWValid = 1'b0, S_ARValid = 1'b0;
  logic        S_AWReady, S_ARReady;
  logic [31:0] S_WData = 32'd0;
  logic [3:0]  S_WStrb = 4'd0;
  logic        S_WLast = 1'b0, S_WValid = 1'b0, S_WReady;
  logic [7:0]  S_BID, S_RID;
  logic [1:0]  S_BResp, S_RResp;
  logic        S_BValid, S_BReady = 1'b1;
  logic [31:0] S_RData;
  logic        S_RLast, S_RValid, S_RReady = 1'b0;
  logic        dma_done = 1'b0;
  logic        DMAEN, DMA_interrupt;
  logic [31:0] DMASRC, DMADST, DMALEN;

  int          errors = 0;
  int          checks = 0;
  rbeat_t      rq[$];
  bexp_t       bq[$];
  rbeat_t      r_exp, r_prev, r_now;
  bexp_t       b_exp;
  logic        r_stall = 1'b0;
  logic [31:0] wbuf [16];
  logic [31:0] rexp_d [16];
  logic [1:0]  rexp_r [16];

  dma_cfg_slave dut (
    .clk(clk), .rst(rst),
    .S_AWID(S_AWID), .S_AWAddr(S_AWAddr), .S_AWLen(S_AWLen), .S_AWSize(S_AWSize),
    .S_AWBurst(S_AWBurst), .S_AWValid(S_AWValid), .S_AWReady(S_AWReady),
    .S_WData(S_WData), .S_WStrb(S_WStrb), .S_WLast(S_WLast), .S_WValid(S_WValid),
    .S_WReady(S_WReady),
    .S_BID(S_BID), .S_BResp(S_BResp), .S_BValid(S_BValid), .S_BReady(S_BReady),
    .S_ARID(S_ARID), .S_ARAddr(S_ARAddr), .S_ARLen(S_ARLen), .S_ARSize(S_ARSize),
    .S_ARBurst(S_ARBurst), .S_ARValid(S_ARValid), .S_ARReady(S_ARReady),
    .S_RID(S_RID), .S_RData(S_RData), .S_RResp(S_RResp), .S_RLast(S_RLast),
    .S_RValid(S_RValid), .S_RReady(S_RReady),
    .dma_done(dma_done), .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST),
    .DMALEN(DMALEN), .DMA_interrupt(DMA_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // B monitor: pop expected response on every B handshake.
  always @(negedge clk) begin
    if (rst && S_BValid && S_BReady) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got id=%h resp=%h expected none", S_BID, S_BResp);
      end else begin
        b_exp = bq.pop_front();
        if (S_BID !== b_exp.id || S_BResp !== b_exp.resp) begin
          errors++;
          $display("FAIL b_resp: got id=%h resp=%h expected id=%h resp=%h",
                   S_BID, S_BResp, b_exp.id, b_exp.resp);
        end
      end
    end
  end

  // R monitor: stability while stalled, and scoreboard compare on each R handshake.
  always @(negedge clk) begin
    r_now = '{id: S_RID, data: S_RData, resp: S_RResp, last: S_RLast};
    if (rst && S_RValid) begin
      if (r_stall) begin
        checks++;
        if (r_now !== r_prev) begin
          errors++;
          $display("FAIL r_stable: got %h expected %h", r_now, r_prev);
        end
      end
      if (S_RReady) begin
        checks++;
        r_stall = 1'b0;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got %h expected none", r_now);
        end else begin
          r_exp = rq.pop_front();
          if (r_now !== r_exp) begin
            errors++;
            $display("FAIL r_beat: got id=%h data=%h resp=%h last=%b expected id=%h data=%h resp=%h last=%b",
                     r_now.id, r_now.data, r_now.resp, r_now.last,
                     r_exp.id, r_exp.data, r_exp.resp, r_exp.last);
          end
        end
      end else begin
        r_stall = 1'b1;
        r_prev  = r_now;
      end
    end else begin
      r_stall = 1'b0;
    end
  end

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int nb, input logic [3:0] strb,
                          input logic [1:0] resp, input bit done_last);
    int n;
    bexp_t e;
    e.id = id;
    e.resp = resp;
    bq.push_back(e);
    @(posedge clk); #1;
    S_AWID = id; S_AWAddr = addr; S_AWLen = len; S_AWSize = 3'd2; S_AWBurst = burst;
    S_AWValid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!S_AWReady && n < 20);
    if (!S_AWReady) timeout("aw_ready");
    @(posedge clk); #1;
    S_AWValid = 1'b0;
    chk("wready_latency", {31'd0, S_WReady}, 32'd1);
    for (int i = 0; i < nb; i++) begin
      S_WData = wbuf[i]; S_WStrb = strb; S_WLast = (i == nb - 1); S_WValid = 1'b1;
      if (done_last && i == nb - 1) dma_done = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!S_WReady && n < 20);
      if (!S_WReady) timeout("w_ready");
      @(posedge clk); #1;
      S_WValid = 1'b0; S_WLast = 1'b0; dma_done = 1'b0;
    end
    chk("bvalid_latency", {31'd0, S_BValid}, 32'd1);
    n = 0;
    while (bq.size() > 0 && n < 20) begin @(posedge clk); #1; n++; end
    if (bq.size() > 0) begin timeout("b_resp"); bq.delete(); end
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input bit toggle);
    int n;
    rbeat_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id; e.data = rexp_d[i]; e.resp = rexp_r[i]; e.last = (i == int'(len));
      rq.push_back(e);
    end
    @(posedge clk); #1;
    S_RReady = 1'b0;
    S_ARID = id; S_ARAddr = addr; S_ARLen = len; S_ARSize = 3'd2; S_ARBurst = burst;
    S_ARValid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!S_ARReady && n < 20);
    if (!S_ARReady) timeout("ar_ready");
    @(posedge clk); #1;
    S_ARValid = 1'b0;
    chk("rvalid_latency", {31'd0, S_RValid}, 32'd1);
    n = 0;
    while (rq.size() > 0 && n < 100) begin
      S_RReady = toggle ? ~S_RReady : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    S_RReady = 1'b0;
    if (rq.size() > 0) begin timeout("r_beats"); rq.delete(); end
  endtask

  task automatic chk_regs(input string tag, input logic en, input logic [31:0] src,
                          input logic [31:0] dst, input logic [31:0] len);
    chk({tag, "_en"},  {31'd0, DMAEN}, {31'd0, en});
    chk({tag, "_src"}, DMASRC, src);
    chk({tag, "_dst"}, DMADST, dst);
    chk({tag, "_len"}, DMALEN, len);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {31'd0, S_AWReady}, 32'd0);
    chk("rst_arready", {31'd0, S_ARReady}, 32'd0);
    chk("rst_valids", {29'd0, S_WReady, S_BValid, S_RValid}, 32'd0);
    chk("rst_rdata", S_RData, 32'd0);
    chk("rst_payload", {20'd0, S_BID, S_BResp, S_RLast, S_RResp[0]}, 32'd0);
    chk("rst_irq", {31'd0, DMA_interrupt}, 32'd0);
    chk_regs("rst", 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("awready_pre", {31'd0, S_AWReady}, 32'd0);
    @(posedge clk); #1;
    chk("awready_post", {31'd0, S_AWReady}, 32'd1);
    chk("arready_post", {31'd0, S_ARReady}, 32'd1);

    // Single write to SRC
    wbuf[0] = 32'h0000_1000;
    do_write(8'h3C, 32'h04, 4'd0, 2'b01, 1, 4'hF, 2'b00, 1'b0);
    chk("single_src", DMASRC, 32'h0000_1000);

    // INCR 4-beat write covering CTRL..LEN
    wbuf[0] = 32'h1; wbuf[1] = 32'h100; wbuf[2] = 32'h200; wbuf[3] = 32'h10;
    do_write(8'h5A, 32'h00, 4'd3, 2'b01, 4, 4'hF, 2'b00, 1'b0);
    chk_regs("incr4", 1'b1, 32'h100, 32'h200, 32'h10);

    // INCR 4-beat read with RReady toggling
    rexp_d[0] = 32'h100; rexp_d[1] = 32'h200; rexp_d[2] = 32'h10; rexp_d[3] = 32'h0;
    for (int i = 0; i < 4; i++) rexp_r[i] = 2'b00;
    do_read(8'h21, 32'h04, 4'd3, 2'b01, 1'b1);

    // Unmapped read and write
    rexp_d[0] = 32'h0; rexp_r[0] = 2'b10;
    do_read(8'h07, 32'h18, 4'd0, 2'b01, 1'b0);
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(8'h08, 32'h18, 4'd0, 2'b01, 1, 4'hF, 2'b10, 1'b0);
    chk_regs("unmapped_w", 1'b1, 32'h100, 32'h200, 32'h10);

    // FIXED bursts stay on one register
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    do_write(8'h09, 32'h0C, 4'd1, 2'b00, 2, 4'hF, 2'b00, 1'b0);
    chk("fixed_len", DMALEN, 32'h22);
    rexp_d[0] = 32'h22; rexp_d[1] = 32'h22; rexp_r[0] = 2'b00; rexp_r[1] = 2'b00;
    do_read(8'h0A, 32'h0C, 4'd1, 2'b00, 1'b0);

    // INCR burst running off the end of the map: second beat is unmapped
    wbuf[0] = 32'h0; wbuf[1] = 32'h0;
    do_write(8'h0B, 32'h10, 4'd1, 2'b01, 2, 4'hF, 2'b10, 1'b0);
    chk("irq_still_0", {31'd0, DMA_interrupt}, 32'd0);

    // dma_done pulse sets sticky interrupt one cycle later
    @(posedge clk); #1;
    dma_done = 1'b1;
    @(posedge clk); #1;
    dma_done = 1'b0;
    chk("irq_set", {31'd0, DMA_interrupt}, 32'd1);
    rexp_d[0] = 32'h1; rexp_r[0] = 2'b00;
    do_read(8'h0C, 32'h10, 4'd0, 2'b01, 1'b0);

    // W1C coincident with a new done: set wins
    wbuf[0] = 32'h1;
    do_write(8'h0D, 32'h10, 4'd0, 2'b01, 1, 4'hF, 2'b00, 1'b1);
    chk("irq_set_wins", {31'd0, DMA_interrupt}, 32'd1);
    do_write(8'h0E, 32'h10, 4'd0, 2'b01, 1, 4'hF, 2'b00, 1'b0);
    chk("irq_cleared", {31'd0, DMA_interrupt}, 32'd0);

    // Byte-strobed write
    wbuf[0] = 32'h0;
    do_write(8'h0F, 32'h08, 4'd0, 2'b01, 1, 4'hF, 2'b00, 1'b0);
    wbuf[0] = 32'hAABB_CCDD;
    do_write(8'h10, 32'h08, 4'd0, 2'b01, 1, 4'b0010, 2'b00, 1'b0);
    chk("strobe_dst", DMADST, 32'h0000_CC00);

    // Early WLast: one beat against AWLen=3, no error
    wbuf[0] = 32'h0;
    do_write(8'h11, 32'h00, 4'd3, 2'b01, 1, 4'hF, 2'b00, 1'b0);
    chk("early_wlast_en", {31'd0, DMAEN}, 32'd0);

    // Reset during a stalled read burst
    wbuf[0] = 32'h1;
    do_write(8'h12, 32'h00, 4'd0, 2'b01, 1, 4'hF, 2'b00, 1'b0);
    @(posedge clk); #1;
    S_RReady = 1'b0;
    S_ARID = 8'h13; S_ARAddr = 32'h04; S_ARLen = 4'd3; S_ARBurst = 2'b01; S_ARValid = 1'b1;
    @(posedge clk); #1;
    S_ARValid = 1'b0;
    chk("midrst_rvalid_pre", {31'd0, S_RValid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", {31'd0, S_RValid}, 32'd0);
    chk_regs("midrst", 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_rvalid", {31'd0, S_RValid}, 32'd0);
    chk("post_rst_bvalid", {31'd0, S_BValid}, 32'd0);
    chk("post_rst_awready", {31'd0, S_AWReady}, 32'd1);
    chk("queues_empty", rq.size() + bq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_cfg_slave.md
# dma_cfg_slave

AXI4 slave port through which the CPU programs the DMA engine and observes its completion. It responds on the CPU-side bus to single and INCR/FIXED burst reads and writes, and holds the DMA configuration registers (enable, source, destination, length). It exports those registers to the DMA engine and collects the engine's done pulse into a sticky, write-1-to-clear interrupt.

## Interface
- ID_W, 8, AXI ID width (slave-side, master ID prepended by interconnect)
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (fixed 32; registers are 32-bit)
- LEN_W, 4, AXI burst length width (1–16 beats)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- S_AWID/S_AWAddr/S_AWLen/S_AWSize/S_AWBurst  in  ID_W/ADDR_W/LEN_W/3/2  write address
- S_AWValid  in  1;  S_AWReady  out  1
- S_WData/S_WStrb/S_WLast/S_WValid  in  DATA_W/4/1/1;  S_WReady  out  1
- S_BID  out  ID_W;  S_BResp  out  2;  S_BValid  out  1;  S_BReady  in  1
- S_ARID/S_ARAddr/S_ARLen/S_ARSize/S_ARBurst  in  ID_W/ADDR_W/LEN_W/3/2  read address
- S_ARValid  in  1;  S_ARReady  out  1
- S_RID  out  ID_W;  S_RData  out  DATA_W;  S_RResp  out  2;  S_RLast  out  1;  S_RValid  out  1;  S_RReady  in  1
- dma_done  in  1  single-cycle completion pulse from DMA engine
- DMAEN  out  1;  DMASRC/DMADST/DMALEN  out  32 each  register contents to engine
- DMA_interrupt  out  1  sticky done flag

## Operation
- Register map (offset = addr[5:2]): 0x00 CTRL (bit0 DMAEN), 0x04 SRC, 0x08 DST, 0x0C LEN, 0x10 STATUS (bit0 done, W1C). Offsets ≥0x14: unmapped.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE. W_IDLE: AWReady=1; handshake latches AWID, AWAddr, AWLen, AWBurst, clears error flag. W_DATA: WReady=1; each beat writes byte lanes selected by WStrb at current address, then address += 4 if INCR, unchanged if FIXED. Beat with WLast → W_RESP. W_RESP: BValid=1, BID=latched ID, BResp=OKAY(00) or SLVERR(10) if any beat hit unmapped; leave on BReady.
- Read FSM R_IDLE → R_DATA → R_IDLE. R_IDLE: ARReady=1; latch ARID, addr, len, burst; beat counter=0. R_DATA: RValid=1, RData=register at current address (unmapped: 0, RResp=SLVERR, else OKAY), RLast when counter==len; on RReady advance address/counter; RLast&RReady → R_IDLE.
- STATUS: set by dma_done; cleared by write with WStrb[0]=1, WData[0]=1. Set and clear same cycle: set wins. DMA_interrupt = STATUS[0].
- Writes to STATUS bits [31:1] and CTRL bits [31:1] ignored; read as 0.
- Read and write FSMs independent and may run concurrently; read in the cycle of a write to the same register returns the old value.
- WLast earlier/later than AWLen: WLast alone terminates the burst; no error.

## Timing
- Reset (rst=0): both FSMs idle; all ready/valid outputs 0; S_BID, S_BResp, S_RID, S_RData, S_RResp, S_RLast 0; all registers 0; DMA_interrupt 0. AWReady/ARReady rise the first cycle after release.
- AW handshake cycle N → WReady=1 from N+1; one beat accepted per cycle while WValid.
- Final W beat cycle M → BValid=1 at M+1, register update visible on outputs at M+1.
- AR handshake cycle N → RValid=1 at N+1; back-to-back beats with RReady held high.
- dma_done at cycle K → DMA_interrupt=1 at K+1.
- Reset mid-burst: transaction abandoned, FSMs idle, registers cleared; no response issued.
- Valid outputs never drop before handshake; payload stable while valid and not ready.

## Structure
- Shared package dma_pkg: register offsets, RESP_OKAY/RESP_SLVERR, burst codes, write/read state enums.
- One sub-module natural: dma_cfg_regs (register storage, byte-strobed write port, combinational read decode, done set/clear logic).

## Test plan
- Single write 0x04 ← 0x0000_1000, WStrb=F → DMASRC=0x1000, BResp=00, BID echoes AWID.
- INCR 4-beat write at 0x00 data {1,0x100,0x200,0x10} → DMAEN=1, SRC=0x100, DST=0x200, LEN=0x10; one B response.
- INCR 4-beat read at 0x04 with RReady toggling → RData 0x100,0x200,0x10,0, RLast on 4th only, data stable while stalled.
- Read 0x18 → RData=0, RResp=10; write 0x18 → BResp=10, registers unchanged.
- dma_done pulse → DMA_interrupt=1; write STATUS 0x1 coincident with new dma_done → stays 1; later write 0x1 alone → 0.
- WStrb=4'b0010 write 0xAABBCCDD to 0x08 (DST=0) → DST=0x0000_CC00; reset asserted mid read burst → RValid=0 next cycle, all registers 0.
